wb_byte_master: RTL and testbench

Byte-stream-driven Wishbone classic bus initiator for the or1k SoC. It turns a simple command byte stream into single 32-bit Wishbone reads and writes, so a debug UART or test host can load, peek and poke the ROM/RAM and GPIO slaves alongside the mor1kx core. It drives a master port on the data-bus arbiter and returns a status/data byte stream.

---
 rtl/wb_byte_master_pkg.sv | 26 ++
 rtl/wb_byte_master_if.sv | 40 ++++
 rtl/wb_byte_master.sv | 163 ++++++++++++++++
 tb/tb_wb_byte_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_byte_master_pkg.sv
// Shared opcodes, status codes and FSM state type for the byte-stream Wishbone initiator.
package wb_byte_master_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;

    localparam logic [7:0] ST_ACK     = 8'h00;
    localparam logic [7:0] ST_ERR     = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_RETRY   = 8'h03;
    localparam logic [7:0] ST_BADOP   = 8'hEE;

    typedef enum logic [2:0] {
        S_OP,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_STATUS,
        S_RDATA
    } state_t;

    function automatic logic is_bus_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/wb_byte_master_if.sv
// Command stream, response stream and Wishbone master signals of wb_byte_master.
interface wb_byte_master_if;

    logic [7:0]  cmd_data_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;

    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    modport master (
        input  cmd_data_i, cmd_valid_i, rsp_ready_i,
        output cmd_ready_o, rsp_data_o, rsp_valid_o,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        output cmd_data_i, cmd_valid_i, rsp_ready_i,
        input  cmd_ready_o, rsp_data_o, rsp_valid_o,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

endinterface

// File: rtl/wb_byte_master.sv
// Turns a command byte stream into single classic Wishbone reads/writes and
// returns a status byte (plus 4 data bytes on a successful read).
module wb_byte_master
    import wb_byte_master_pkg::*;
#(
    parameter int TIMEOUT   = 256,
    parameter int MAX_RETRY = 3
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    wb_byte_master_if.master bus,
    output logic             busy_o
);

    localparam int WAIT_W  = $clog2(TIMEOUT);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    state_t               state_reg;
    logic [31:0]          addr_reg;
    logic [31:0]          data_reg;
    logic [1:0]           byte_cnt_reg;
    logic [WAIT_W-1:0]    wait_cnt_reg;
    logic [RETRY_W-1:0]   retry_cnt_reg;
    logic                 cyc_reg;
    logic                 we_reg;
    logic [7:0]           status_reg;

    logic cmd_fire;
    logic rsp_fire;
    logic last_byte;

    assign cmd_fire  = bus.cmd_valid_i && bus.cmd_ready_o;
    assign rsp_fire  = bus.rsp_valid_o && bus.rsp_ready_i;
    assign last_byte = (byte_cnt_reg == 2'd3);

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_reg     <= S_OP;
            addr_reg      <= '0;
            data_reg      <= '0;
            byte_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            status_reg    <= '0;
        end else begin
            case (state_reg)
                S_OP: begin
                    if (cmd_fire) begin
                        byte_cnt_reg  <= '0;
                        wait_cnt_reg  <= '0;
                        retry_cnt_reg <= '0;
                        if (is_bus_op(bus.cmd_data_i)) begin
                            we_reg    <= (bus.cmd_data_i == OP_WRITE);
                            state_reg <= S_ADDR;
                        end else begin
                            we_reg     <= 1'b0;
                            status_reg <= ST_BADOP;
                            state_reg  <= S_STATUS;
                        end
                    end
                end
                S_ADDR: begin
                    if (cmd_fire) begin
                        addr_reg     <= {addr_reg[23:0], bus.cmd_data_i};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            if (we_reg) begin
                                state_reg <= S_DATA;
                            end else begin
                                state_reg <= S_BUS;
                                cyc_reg   <= 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (cmd_fire) begin
                        data_reg     <= {data_reg[23:0], bus.cmd_data_i};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            state_reg <= S_BUS;
                            cyc_reg   <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    // cyc low inside BUS is the single idle cycle between retry attempts
                    if (!cyc_reg) begin
                        cyc_reg <= 1'b1;
                    end else if (bus.wbm_err_i) begin
                        cyc_reg    <= 1'b0;
                        status_reg <= ST_ERR;
                        state_reg  <= S_STATUS;
                    end else if (bus.wbm_ack_i) begin
                        cyc_reg    <= 1'b0;
                        status_reg <= ST_ACK;
                        state_reg  <= S_STATUS;
                        if (!we_reg) begin
                            data_reg <= bus.wbm_dat_i;
                        end
                    end else if (bus.wbm_rty_i) begin
                        cyc_reg <= 1'b0;
                        if (retry_cnt_reg < RETRY_LIMIT) begin
                            retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
                            wait_cnt_reg  <= '0;
                        end else begin
                            status_reg <= ST_RETRY;
                            state_reg  <= S_STATUS;
                        end
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        cyc_reg    <= 1'b0;
                        status_reg <= ST_TIMEOUT;
                        state_reg  <= S_STATUS;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                S_STATUS: begin
                    if (rsp_fire) begin
                        byte_cnt_reg <= '0;
                        if (!we_reg && (status_reg == ST_ACK)) begin
                            state_reg <= S_RDATA;
                        end else begin
                            state_reg <= S_OP;
                        end
                    end
                end
                S_RDATA: begin
                    if (rsp_fire) begin
                        data_reg     <= {data_reg[23:0], 8'h00};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            state_reg <= S_OP;
                        end
                    end
                end
                default: state_reg <= S_OP;
            endcase
        end
    end

    // Stream handshakes come only from registered state; reset masks them to 0.
    assign bus.cmd_ready_o = wb_rst_n &&
                             ((state_reg == S_OP) || (state_reg == S_ADDR) || (state_reg == S_DATA));
    assign bus.rsp_valid_o = wb_rst_n && ((state_reg == S_STATUS) || (state_reg == S_RDATA));
    assign bus.rsp_data_o  = !bus.rsp_valid_o         ? 8'h00 :
                             (state_reg == S_STATUS)  ? status_reg : data_reg[31:24];
    assign busy_o          = wb_rst_n && (state_reg != S_OP);

    assign bus.wbm_adr_o = {addr_reg[31:2], 2'b00};
    assign bus.wbm_dat_o = data_reg;
    assign bus.wbm_sel_o = cyc_reg ? 4'hF : 4'h0;
    assign bus.wbm_we_o  = we_reg && cyc_reg;
    assign bus.wbm_cyc_o = cyc_reg;
    assign bus.wbm_stb_o = cyc_reg;
    assign bus.wbm_cti_o = 3'b000;
    assign bus.wbm_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: vector table of single accesses plus reset corner cases.
module tb_wb_byte_master;
    import wb_byte_master_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    wb_byte_master_if bus();

    wb_byte_master #(.TIMEOUT(8), .MAX_RETRY(3)) dut (
        .wb_clk   (clk),
        .wb_rst_n (rst_n),
        .bus      (bus),
        .busy_o   (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: terminations: 0 ack, 1 err, 2 none, 3 err+ack; first rty_n attempts get rty
    int          epoch = 0;
    int          slv_wait = 0, slv_rty_n = 0, slv_term = 0;
    logic [31:0] slv_rdata = '0;
    int          slv_cnt = 0, slv_attempt = 0, slv_epoch = 0;

    always_comb begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_rty_i = 1'b0;
        bus.wbm_dat_i = slv_rdata;
        if (bus.wbm_stb_o && slv_cnt == slv_wait) begin
            if (slv_attempt < slv_rty_n) bus.wbm_rty_i = 1'b1;
            else if (slv_term == 0) bus.wbm_ack_i = 1'b1;
            else if (slv_term == 1) bus.wbm_err_i = 1'b1;
            else if (slv_term == 3) begin
                bus.wbm_err_i = 1'b1;
                bus.wbm_ack_i = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (slv_epoch != epoch) begin
            slv_epoch   <= epoch;
            slv_cnt     <= 0;
            slv_attempt <= 0;
        end else if (bus.wbm_stb_o) begin
            if (bus.wbm_ack_i || bus.wbm_err_i || bus.wbm_rty_i) begin
                slv_cnt     <= 0;
                slv_attempt <= slv_attempt + 1;
            end else begin
                slv_cnt <= slv_cnt + 1;
            end
        end else begin
            slv_cnt <= 0;
        end
    end

    // Bus monitor, sampled on the falling edge
    int          mon_epoch = 0, stb_cycles = 0, pulses = 0, idle_run = 0;
    logic        prev_stb = 1'b0, gap_bad = 1'b0, unstable = 1'b0, shape_bad = 1'b0;
    logic [31:0] cap_adr = '0, cap_dat = '0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_sel = '0;

    always @(negedge clk) begin
        if (mon_epoch != epoch) begin
            mon_epoch  <= epoch;
            stb_cycles <= 0;
            pulses     <= 0;
            idle_run   <= 0;
            prev_stb   <= 1'b0;
            gap_bad    <= 1'b0;
            unstable   <= 1'b0;
            shape_bad  <= 1'b0;
        end else begin
            prev_stb <= bus.wbm_stb_o;
            if (bus.wbm_cyc_o !== bus.wbm_stb_o) shape_bad <= 1'b1;
            if (bus.wbm_stb_o) begin
                stb_cycles <= stb_cycles + 1;
                idle_run   <= 0;
                if (!prev_stb) begin
                    pulses <= pulses + 1;
                    if (pulses > 0 && idle_run != 1) gap_bad <= 1'b1;
                end
                if (stb_cycles == 0) begin
                    cap_adr <= bus.wbm_adr_o;
                    cap_dat <= bus.wbm_dat_o;
                    cap_we  <= bus.wbm_we_o;
                    cap_sel <= bus.wbm_sel_o;
                end else if (bus.wbm_adr_o !== cap_adr || bus.wbm_dat_o !== cap_dat ||
                             bus.wbm_we_o !== cap_we || bus.wbm_sel_o !== cap_sel) begin
                    unstable <= 1'b1;
                end
            end else begin
                idle_run <= idle_run + 1;
                if (bus.wbm_sel_o !== 4'h0) shape_bad <= 1'b1;
            end
        end
    end

    // Stream tasks: called and return on a falling edge
    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        bus.cmd_data_i  = b;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.cmd_ready_o === 1'b1) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        bus.cmd_valid_i = 1'b0;
        if (!done) check("cmd_ready_wait", 32'(done), 32'd1);
    endtask

    task automatic recv_byte(input bit toggle, output logic [7:0] b);
        bit          ok = 0;
        bit          held_seen = 0;
        logic [7:0]  held = '0;
        b = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            bus.rsp_ready_i = toggle ? (i % 2 == 1) : 1'b1;
            if (bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i) begin
                b  = bus.rsp_data_o;
                ok = 1;
            end else if (bus.rsp_valid_o === 1'b1) begin
                held      = bus.rsp_data_o;
                held_seen = 1;
            end
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b0;
        if (!ok) check("rsp_valid_wait", 32'(ok), 32'd1);
        if (held_seen) check("rsp_hold", {24'h0, held}, {24'h0, b});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stream"}, {21'h0, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_data_o, busy},
              32'h0);
        check({tag, "_ctrl"}, {25'h0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o},
              32'h0);
        check({tag, "_adr"}, bus.wbm_adr_o, 32'h0);
        check({tag, "_dat"}, bus.wbm_dat_o, 32'h0);
        check({tag, "_cti_bte"}, {27'h0, bus.wbm_cti_o, bus.wbm_bte_o}, 32'h0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        int          rty_n;
        int          term;
        logic [31:0] rdata;
        bit          toggle;
        logic [7:0]  exp_status;
        int          exp_stb;
        int          exp_pulses;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0]  b;
        logic [7:0]  status;
        logic [31:0] rd = '0;
        bit          bus_op = (v.op == OP_WRITE) || (v.op == OP_READ);
        epoch++;
        slv_wait  = v.wait_n;
        slv_rty_n = v.rty_n;
        slv_term  = v.term;
        slv_rdata = v.rdata;
        @(negedge clk);
        @(negedge clk);
        send_byte(v.op);
        if (bus_op) begin
            for (int k = 3; k >= 0; k--) send_byte(v.addr[8*k +: 8]);
            if (v.op == OP_WRITE)
                for (int k = 3; k >= 0; k--) send_byte(v.wdata[8*k +: 8]);
            check($sformatf("v%0d_stb_rise", idx), 32'(bus.wbm_stb_o), 32'd1);
        end else begin
            check($sformatf("v%0d_badop_rsp_valid", idx), 32'(bus.rsp_valid_o), 32'd1);
        end
        recv_byte(v.toggle, status);
        check($sformatf("v%0d_status", idx), {24'h0, status}, {24'h0, v.exp_status});
        if (v.op == OP_READ && v.exp_status == ST_ACK) begin
            for (int k = 0; k < 4; k++) begin
                recv_byte(v.toggle, b);
                rd = {rd[23:0], b};
            end
            check($sformatf("v%0d_rdata", idx), rd, v.rdata);
        end
        @(negedge clk);
        check($sformatf("v%0d_idle", idx), {31'h0, busy}, 32'h0);
        check($sformatf("v%0d_stb_cycles", idx), 32'(stb_cycles), 32'(v.exp_stb));
        check($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(v.exp_pulses));
        check($sformatf("v%0d_shape", idx), {29'h0, gap_bad, unstable, shape_bad}, 32'h0);
        if (v.exp_stb > 0) begin
            check($sformatf("v%0d_adr", idx), cap_adr, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d_we_sel", idx), {27'h0, cap_we, cap_sel},
                  {27'h0, (v.op == OP_WRITE), 4'hF});
            if (v.op == OP_WRITE) check($sformatf("v%0d_wdat", idx), cap_dat, v.wdata);
        end
        $display("vec %0d op=%02h adr=%08h status=%02h rdata=%08h stb_cycles=%0d pulses=%0d",
                 idx, v.op, v.addr, status, rd, stb_cycles, pulses);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t fresh;
        bus.cmd_data_i  = '0;
        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;

        //           op        addr          wdata         wt rty trm rdata        tgl status      stb pls
        vecs[0] = '{OP_WRITE, 32'h00000010, 32'hDEADBEEF, 0, 0,  0, 32'h0,        0, ST_ACK,     1, 1};
        vecs[1] = '{OP_READ,  32'h00000004, 32'h0,        3, 0,  0, 32'h12345678, 1, ST_ACK,     4, 1};
        vecs[2] = '{OP_WRITE, 32'h00000020, 32'h55AA33CC, 0, 2,  0, 32'h0,        0, ST_ACK,     3, 3};
        vecs[3] = '{OP_READ,  32'h00000008, 32'h0,        0, 99, 0, 32'h0,        0, ST_RETRY,   4, 4};
        vecs[4] = '{OP_READ,  32'h0000000C, 32'h0,        0, 0,  2, 32'h0,        0, ST_TIMEOUT, 8, 1};
        vecs[5] = '{OP_WRITE, 32'h00000014, 32'h01020304, 0, 0,  3, 32'h0,        0, ST_ERR,     1, 1};
        vecs[6] = '{8'h41,    32'h0,        32'h0,        0, 0,  0, 32'h0,        0, ST_BADOP,   0, 0};
        vecs[7] = '{OP_READ,  32'h80000013, 32'h0,        1, 0,  0, 32'hA5C3E1F0, 1, ST_ACK,     2, 1};
        vecs[8] = '{OP_READ,  32'h00000018, 32'h0,        2, 0,  1, 32'hFFFFFFFF, 0, ST_ERR,     3, 1};

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 32'(bus.cmd_ready_o), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset after two address bytes discards the partial command
        send_byte(OP_READ);
        send_byte(8'h00);
        send_byte(8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midcmd_reset");
        rst_n = 1'b1;
        #1;
        check("midcmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        @(negedge clk);
        fresh = '{OP_READ, 32'h00000030, 32'h0, 0, 0, 0, 32'hCAFEF00D, 0, ST_ACK, 1, 1};
        run_vec(9, fresh);

        // Reset while strobe is waiting on a silent slave
        epoch++;
        slv_term  = 2;
        slv_rty_n = 0;
        @(negedge clk);
        send_byte(OP_READ);
        for (int k = 0; k < 4; k++) send_byte(8'h40);
        @(negedge clk);
        check("midbus_stb_high", 32'(bus.wbm_stb_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midbus_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("midbus_recovered", {30'h0, bus.cmd_ready_o, busy}, 32'h2);
        $display("midbus reset transaction done stb=%0d", bus.wbm_stb_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
